// File: rtl/factor_game_pkg.sv
// -----------------------------------------------------------------------------
// factor_game_pkg
// Shared definitions for the factorization game controller:
//   - state_e     : game state codes as seen on the STATE bus
//   - LFSR_TAPS   : feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - LFSR_SEED   : non-zero reset value of the question LFSR
//   - factor_prime: switch factor code -> prime (0 marks an invalid code)
//   - qtab        : question ROM, 16 composite values selected by LFSR[3:0]
// -----------------------------------------------------------------------------
package factor_game_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'b0000,
      ST_READY    = 4'b0010,
      ST_QUESTION = 4'b0011,
      ST_INPUT    = 4'b0100,
      ST_DRAW     = 4'b0110,
      ST_WRONG    = 4'b0111,
      ST_GOOD     = 4'b1000,
      ST_OUCH     = 4'b1001,
      ST_WIN      = 4'b1010,
      ST_LOSE     = 4'b1011
   } state_e;

   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   function automatic logic [2:0] factor_prime(input logic [3:0] code);
      logic [2:0] p;
      case (code)
         4'd1:    p = 3'd2;
         4'd2:    p = 3'd3;
         4'd3:    p = 3'd5;
         4'd4:    p = 3'd7;
         default: p = 3'd0;
      endcase
      return p;
   endfunction

   function automatic logic [6:0] qtab(input logic [3:0] idx);
      logic [6:0] v;
      case (idx)
         4'd0:    v = 7'd4;
         4'd1:    v = 7'd6;
         4'd2:    v = 7'd8;
         4'd3:    v = 7'd9;
         4'd4:    v = 7'd12;
         4'd5:    v = 7'd15;
         4'd6:    v = 7'd18;
         4'd7:    v = 7'd20;
         4'd8:    v = 7'd21;
         4'd9:    v = 7'd24;
         4'd10:   v = 7'd27;
         4'd11:   v = 7'd30;
         4'd12:   v = 7'd35;
         4'd13:   v = 7'd42;
         4'd14:   v = 7'd45;
         default: v = 7'd98;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/factor_game_ctrl_bin2bcd7.sv
// -----------------------------------------------------------------------------
// bin2bcd7
// Combinational 7-bit binary to two-digit BCD (shift-and-add-3).
// Valid for inputs 0..99, which covers every question value.
//   bin  in  7  binary value
//   tens out 4  tens digit, BCD
//   ones out 4  ones digit, BCD
// -----------------------------------------------------------------------------
module bin2bcd7 (
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic [14:0] sh_s;

   // Double-dabble: adjust each BCD column before every left shift
   always_comb begin
      sh_s = {8'd0, bin};
      for (int i = 0; i < 7; i++) begin
         sh_s[10:7]  = (sh_s[10:7]  > 4'd4) ? (sh_s[10:7]  + 4'd3) : sh_s[10:7];
         sh_s[14:11] = (sh_s[14:11] > 4'd4) ? (sh_s[14:11] + 4'd3) : sh_s[14:11];
         sh_s        = {sh_s[13:0], 1'b0};
      end
      ones = sh_s[10:7];
      tens = sh_s[14:11];
   end

endmodule

// File: rtl/factor_game_ctrl.sv
// -----------------------------------------------------------------------------
// factor_game_ctrl
// Factorization game controller. Each round a composite question is drawn
// from a ROM indexed by a free-running LFSR, shown on QUE/QUE_T, and the
// player enters its prime factors on SW_DIN + BTN_ENT. A wrong or late
// entry ends the round; after ROUNDS rounds the game ends in WIN/LOSE/DRAW.
// Ports:
//   CLK        in  1  clock, all logic on posedge
//   nRST       in  1  synchronous active-low reset
//   TICK       in  1  one-cycle timebase enable
//   BTN_START  in  1  start / restart pulse
//   BTN_ENT    in  1  commit SW_DIN pulse
//   SW_DIN     in  4  factor code 1=2, 2=3, 3=5, 4=7
//   STATE      out 4  game state code
//   QUE, QUE_T out 4  question ones / tens digit, BCD
//   DIN        out 4  last accepted factor code (0 = none)
//   ROUND      out 4  current round, 1-based
//   SCORE      out 4  rounds answered correctly
// -----------------------------------------------------------------------------
module factor_game_ctrl
   import factor_game_pkg::*;
#(
   parameter int unsigned ROUNDS       = 5,
   parameter int unsigned READY_TICKS  = 2,
   parameter int unsigned QUE_TICKS    = 3,
   parameter int unsigned INPUT_TICKS  = 10,
   parameter int unsigned RESULT_TICKS = 2
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       TICK,
   input  logic       BTN_START,
   input  logic       BTN_ENT,
   input  logic [3:0] SW_DIN,
   output logic [3:0] STATE,
   output logic [3:0] QUE,
   output logic [3:0] QUE_T,
   output logic [3:0] DIN,
   output logic [3:0] ROUND,
   output logic [3:0] SCORE
);

   localparam logic [3:0] READY_LAST  = 4'(READY_TICKS - 1);
   localparam logic [3:0] QUE_LAST    = 4'(QUE_TICKS - 1);
   localparam logic [3:0] INPUT_LAST  = 4'(INPUT_TICKS - 1);
   localparam logic [3:0] RESULT_LAST = 4'(RESULT_TICKS - 1);
   localparam logic [3:0] ROUNDS_C    = 4'(ROUNDS);
   localparam logic [4:0] ROUNDS_W    = 5'(ROUNDS);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [6:0] rem_q, rem_d;
   logic [3:0] que_q, que_d;
   logic [3:0] que_t_q, que_t_d;
   logic [3:0] din_q, din_d;
   logic [3:0] round_q, round_d;
   logic [3:0] score_q, score_d;

   logic [6:0] qval_s;
   logic [3:0] qval_tens_s;
   logic [3:0] qval_ones_s;
   logic [2:0] prime_s;
   logic [6:0] quo_s;
   logic       div_ok_s;
   logic [4:0] score_x2_s;

   assign qval_s     = qtab(lfsr_q[3:0]);
   assign prime_s    = factor_prime(SW_DIN);
   assign score_x2_s = {score_q, 1'b0};

   bin2bcd7 u_bcd (
      .bin  (qval_s),
      .tens (qval_tens_s),
      .ones (qval_ones_s)
   );

   // Quotient of the remaining value by the entered prime, and whether it divides exactly
   always_comb begin
      quo_s = 7'd0;
      case (prime_s)
         3'd2:    quo_s = rem_q / 7'd2;
         3'd3:    quo_s = rem_q / 7'd3;
         3'd5:    quo_s = rem_q / 7'd5;
         3'd7:    quo_s = rem_q / 7'd7;
         default: quo_s = 7'd0;
      endcase
      div_ok_s = (prime_s != 3'd0) && ((quo_s * {4'd0, prime_s}) == rem_q);
   end

   // Next-state and datapath updates for the game FSM
   always_comb begin
      state_d = state_q;
      lfsr_d  = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      rem_d   = rem_q;
      que_d   = que_q;
      que_t_d = que_t_q;
      din_d   = din_q;
      round_d = round_q;
      score_d = score_q;

      case (state_q)
         ST_IDLE, ST_WIN, ST_LOSE, ST_DRAW: begin
            if (BTN_START) begin
               state_d = ST_READY;
               round_d = 4'd1;
               score_d = 4'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_READY: begin
            if (TICK && (cnt_q == READY_LAST)) begin
               state_d = ST_QUESTION;
               rem_d   = qval_s;
               que_d   = qval_ones_s;
               que_t_d = qval_tens_s;
            end else begin
               state_d = state_q;
            end
         end
         ST_QUESTION: begin
            if (TICK && (cnt_q == QUE_LAST)) begin
               state_d = ST_INPUT;
               din_d   = 4'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_INPUT: begin
            // An accepted entry takes priority over a coinciding final TICK;
            // the counter has then passed the limit, so the next TICK times out.
            if (BTN_ENT && (prime_s != 3'd0)) begin
               din_d = SW_DIN;
               if (!div_ok_s) begin
                  state_d = ST_WRONG;
               end else if (quo_s == 7'd1) begin
                  rem_d   = quo_s;
                  state_d = ST_GOOD;
                  score_d = score_q + 4'd1;
               end else begin
                  rem_d   = quo_s;
                  state_d = state_q;
               end
            end else if (TICK && (cnt_q >= INPUT_LAST)) begin
               state_d = ST_OUCH;
            end else begin
               state_d = state_q;
            end
         end
         ST_GOOD, ST_WRONG, ST_OUCH: begin
            if (TICK && (cnt_q == RESULT_LAST)) begin
               if (round_q < ROUNDS_C) begin
                  round_d = round_q + 4'd1;
                  state_d = ST_READY;
               end else if (score_x2_s > ROUNDS_W) begin
                  state_d = ST_WIN;
               end else if (score_x2_s == ROUNDS_W) begin
                  state_d = ST_DRAW;
               end else begin
                  state_d = ST_LOSE;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = 4'd0;
      end else if (TICK) begin
         cnt_d = cnt_q + 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         lfsr_q  <= LFSR_SEED;
         rem_q   <= 7'd0;
         que_q   <= 4'd0;
         que_t_q <= 4'd0;
         din_q   <= 4'd0;
         round_q <= 4'd0;
         score_q <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         rem_q   <= rem_d;
         que_q   <= que_d;
         que_t_q <= que_t_d;
         din_q   <= din_d;
         round_q <= round_d;
         score_q <= score_d;
      end
   end

   assign STATE = state_q;
   assign QUE   = que_q;
   assign QUE_T = que_t_q;
   assign DIN   = din_q;
   assign ROUND = round_q;
   assign SCORE = score_q;

endmodule
